// File: rtl/rca_word_sequencer.sv
// rtl/rca_word_sequencer.sv - byte-serial wide-word adder front end for an external 8-bit ripple-carry adder
// Optional subtract mode (in_sub port, A-B via inverted B and forced carry-in) enabled by ADDSEQ_SUB_EN.
module rca_word_sequencer #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_a,
    input  logic [8*NUM_BYTES-1:0] in_b,
    input  logic                   in_cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                   in_sub,
`endif
    output logic [7:0]             rca_a,
    output logic [7:0]             rca_b,
    output logic                   rca_cin,
    input  logic [7:0]             rca_sum,
    input  logic                   rca_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_sum,
    output logic                   out_cout
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic            carry_reg;
    logic            accept;
    logic            idx_last;
    logic [W-1:0]    load_b;
    logic            load_c;

`ifdef ADDSEQ_SUB_EN
    // Subtraction is A + ~B + 1; in_cin has no meaning in that mode.
    assign load_b = in_sub ? ~in_b : in_b;
    assign load_c = in_sub | in_cin;
`else
    assign load_b = in_b;
    assign load_c = in_cin;
`endif

    assign accept   = in_valid & in_ready;
    assign idx_last = (idx == IW'(NUM_BYTES - 1));
    assign out_sum  = res_reg;
    assign out_cout = carry_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rca_a      = 8'd0;
        rca_b      = 8'd0;
        rca_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                rca_a   = a_reg[8*idx +: 8];
                rca_b   = b_reg[8*idx +: 8];
                rca_cin = carry_reg;
                if (idx_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Accepting in DONE lets a new operation start in the cycle the result leaves.
                in_ready  = rst_n & out_ready;
                if (out_ready) begin
                    next_state = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_reg     <= in_a;
                        b_reg     <= load_b;
                        carry_reg <= load_c;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    res_reg[8*idx +: 8] <= rca_sum;
                    carry_reg           <= rca_cout;
                    if (!idx_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb/tb_rca_word_sequencer.sv - directed self-checking bench for rca_word_sequencer with a behavioural 8-bit adder
module tb_rca_word_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
`ifdef ADDSEQ_SUB_EN
    logic          in_sub;
`endif
    logic [7:0]    rca_a;
    logic [7:0]    rca_b;
    logic          rca_cin;
    logic [7:0]    rca_sum;
    logic          rca_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic [8:0]    byte_total;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign byte_total = {1'b0, rca_a} + {1'b0, rca_b} + {8'd0, rca_cin};
    assign rca_sum    = byte_total[7:0];
    assign rca_cout   = byte_total[8];

    rca_word_sequencer #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDSEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .rca_a     (rca_a),
        .rca_b     (rca_b),
        .rca_cin   (rca_cin),
        .rca_sum   (rca_sum),
        .rca_cout  (rca_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Presents one operand pair for a single cycle; caller ensures in_ready is high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_valid: out_valid=%0b after %0d edges, required 1", out_valid, edges);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 32'hDEADBEEF;
        in_b      = 32'h01234567;
        in_cin    = 1'b1;
`ifdef ADDSEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum: got %h required 00000000", out_sum); end
        if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %0b required 0", out_cout); end
        if (rca_a !== 8'h0 || rca_b !== 8'h0) begin errors++; $display("FAIL reset_rca_ab: got %h/%h required 00/00", rca_a, rca_b); end
        if (rca_cin !== 1'b0) begin errors++; $display("FAIL reset_rca_cin: got %0b required 0", rca_cin); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_basic;
        int e;
        send(32'h000000FF, 32'h00000001, 1'b0);
        checks++;
        if (rca_a !== 8'hFF || rca_b !== 8'h01) begin errors++; $display("FAIL basic_rca_byte0: got %h/%h required ff/01", rca_a, rca_b); end
        wait_valid(e);
        checks += 4;
        if (e !== 5) begin errors++; $display("FAIL basic_latency: got %0d edges required 5", e); end
        if (out_sum !== 32'h00000100) begin errors++; $display("FAIL basic_sum: got %h required 00000100", out_sum); end
        if (out_cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %0b required 0", out_cout); end
        if (rca_a !== 8'h0 || rca_cin !== 1'b0) begin errors++; $display("FAIL basic_rca_idle: got %h/%0b required 00/0", rca_a, rca_cin); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready); end
    endtask

    task automatic test_carry_chain;
        int e;
        send(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_valid(e);
        checks += 2;
        if (out_sum !== 32'h00000000) begin errors++; $display("FAIL chain_sum: got %h required 00000000", out_sum); end
        if (out_cout !== 1'b1) begin errors++; $display("FAIL chain_cout: got %0b required 1", out_cout); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_stall;
        int e;
        send(32'h12345678, 32'h11111111, 1'b1);
        wait_valid(e);
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b required 1", i, out_valid); end
            if (out_sum !== 32'h2345678A || out_cout !== 1'b0) begin errors++; $display("FAIL stall_sum[%0d]: got %h/%0b required 2345678a/0", i, out_sum, out_cout); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b required 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_follow: got %0b required 1", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        int e;
        int t1;
        send(32'h00010203, 32'h01010101, 1'b0);
        wait_valid(e);
        t1 = cycle;
        checks++;
        if (out_sum !== 32'h01020304 || out_cout !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h/%0b required 01020304/0", out_sum, out_cout); end
        out_ready = 1'b1;
        send(32'hA0000001, 32'h70000001, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_handoff: out_valid=%0b required 0", out_valid); end
        wait_valid(e);
        checks += 2;
        if (cycle - t1 !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d cycles required 5", cycle - t1); end
        if (out_sum !== 32'h10000002 || out_cout !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%0b required 10000002/1", out_sum, out_cout); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int e;
        int seen;
        send(32'h00000011, 32'h00000022, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %0b required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %0b required 0", out_valid); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_result: out_valid high %0d cycles required 0", seen); end
        send(32'h0000FFFF, 32'h00000001, 1'b0);
        wait_valid(e);
        checks++;
        if (out_sum !== 32'h00010000 || out_cout !== 1'b0) begin errors++; $display("FAIL abort_next_op: got %h/%0b required 00010000/0", out_sum, out_cout); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub;
        int e;
        in_sub = 1'b1;
        send(32'd5, 32'd7, 1'b0);
        wait_valid(e);
        checks++;
        if (out_sum !== 32'hFFFFFFFE || out_cout !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %h/%0b required fffffffe/0", out_sum, out_cout); end
        out_ready = 1'b1;
        send(32'd7, 32'd5, 1'b0);
        out_ready = 1'b0;
        wait_valid(e);
        checks++;
        if (out_sum !== 32'h00000002 || out_cout !== 1'b1) begin errors++; $display("FAIL sub_no_borrow: got %h/%0b required 00000002/1", out_sum, out_cout); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
